// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// cordic_pkg : FSM states, quadrant codes and gain/X0 helpers for cordic_sincos
// Revision   : 1.0
// ============================================================================
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [1:0] Q_0 = 2'd0;
  localparam logic [1:0] Q_1 = 2'd1;
  localparam logic [1:0] Q_2 = 2'd2;
  localparam logic [1:0] Q_3 = 2'd3;

  function automatic longint unsigned isqrt64(input longint unsigned v);
    longint unsigned r;
    longint unsigned t;
    r = 64'd0;
    for (int k = 31; k >= 0; k--) begin
      t = r | (64'd1 << k);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // K^2 = prod(1 + 2^-2i), Q30 fixed point
  function automatic longint unsigned cordic_k2_q30(input int iter);
    longint unsigned p;
    p = 64'd1 << 30;
    for (int i = 0; i < iter; i++) p = p + (p >> (2 * i));
    return p;
  endfunction

  function automatic longint unsigned cordic_k_q30(input int iter);
    return isqrt64(cordic_k2_q30(iter) << 30);
  endfunction

  // round(127 * 2^(iw-8) / K)
  function automatic int cordic_x0(input int iw, input int iter);
    longint unsigned k;
    k = cordic_k_q30(iter);
    return int'(((64'd127 << (iw + 22)) + (k >> 1)) / k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// cordic_atan_rom : combinational atan(2^-i) lookup, in units of 2^IW per turn
// Revision        : 1.0
// ============================================================================
module cordic_atan_rom #(
  parameter int IW = 12
) (
  input  logic [3:0]    i_idx,
  output logic [IW-1:0] o_atan
);

  localparam logic [31:0] RND = 32'd1 << (31 - IW);

  // atan(2^-i) as a fraction of a full turn, scaled by 2^32
  logic [31:0] w_turn;

  always_comb begin
    w_turn = 32'd0;
    case (i_idx)
      4'd0:    w_turn = 32'h2000_0000;
      4'd1:    w_turn = 32'h12E4_051E;
      4'd2:    w_turn = 32'h09FB_385B;
      4'd3:    w_turn = 32'h0511_11D4;
      4'd4:    w_turn = 32'h028B_0D43;
      4'd5:    w_turn = 32'h0145_D7E1;
      4'd6:    w_turn = 32'h00A2_F61E;
      4'd7:    w_turn = 32'h0051_7C55;
      4'd8:    w_turn = 32'h0028_BE53;
      4'd9:    w_turn = 32'h0014_5F2F;
      4'd10:   w_turn = 32'h000A_2F98;
      4'd11:   w_turn = 32'h0005_17CC;
      default: w_turn = 32'd0;
    endcase
  end

  assign o_atan = IW'((w_turn + RND) >> (32 - IW));

endmodule
`default_nettype wire

// File: rtl/cordic_sincos.sv
`default_nettype none
// ============================================================================
// cordic_sincos : iterative CORDIC phase -> signed 8-bit sin/cos generator
// Option macro  : CORDIC_SINCOS_DUTY_EN adds offset-binary sin_duty/cos_duty
// Revision      : 1.0
// ============================================================================
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ITER = 8,
  parameter int IW   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        phase,
  output logic              out_valid,
  output logic signed [7:0] sin,
  output logic signed [7:0] cos
`ifdef CORDIC_SINCOS_DUTY_EN
  ,
  output logic [8:0]        sin_duty,
  output logic [8:0]        cos_duty
`endif
);

  localparam int DW = IW + 2;
  localparam logic signed [DW-1:0] X0   = DW'(cordic_x0(IW, ITER));
  localparam logic signed [DW:0]   HALF = (DW+1)'(2 ** (IW - 9));
  localparam logic signed [DW:0]   SMAX = (DW+1)'(127);
  localparam logic signed [DW:0]   SMIN = (DW+1)'(-127);

  state_t               r_state;
  logic [1:0]           r_q;
  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic signed [IW-1:0] r_z;
  logic [3:0]           r_cnt;
  logic                 r_ready;
  logic                 r_valid;
  logic signed [7:0]    r_sin;
  logic signed [7:0]    r_cos;

  logic [IW-1:0]        w_atan;
  logic signed [IW-1:0] w_atan_s;
  logic signed [DW-1:0] w_xs;
  logic signed [DW-1:0] w_ys;
  logic signed [DW-1:0] w_sin_raw;
  logic signed [DW-1:0] w_cos_raw;
  logic signed [7:0]    w_sin;
  logic signed [7:0]    w_cos;

  cordic_atan_rom #(.IW(IW)) u_atan_rom (
    .i_idx  (r_cnt),
    .o_atan (w_atan)
  );

  assign w_atan_s = $signed(w_atan);
  assign w_xs     = r_x >>> r_cnt;
  assign w_ys     = r_y >>> r_cnt;

  // Unfold the first-quadrant rotation back to the requested quadrant
  always_comb begin
    w_sin_raw = r_y;
    w_cos_raw = r_x;
    case (r_q)
      Q_0: begin w_sin_raw = r_y;  w_cos_raw = r_x;  end
      Q_1: begin w_sin_raw = r_x;  w_cos_raw = -r_y; end
      Q_2: begin w_sin_raw = -r_y; w_cos_raw = -r_x; end
      Q_3: begin w_sin_raw = -r_x; w_cos_raw = r_y;  end
    endcase
  end

  function automatic logic signed [7:0] to_sample(input logic signed [DW-1:0] v);
    logic signed [DW:0] t;
    t = ((DW+1)'(v) + HALF) >>> (IW - 8);
    if (t > SMAX)      return 8'sd127;
    else if (t < SMIN) return -8'sd127;
    else               return t[7:0];
  endfunction

  assign w_sin = to_sample(w_sin_raw);
  assign w_cos = to_sample(w_cos_raw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= 2'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= 4'd0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_sin   <= 8'sd0;
      r_cos   <= 8'sd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q     <= phase[7:6];
            r_x     <= X0;
            r_y     <= '0;
            r_z     <= {2'b00, phase[5:0], {(IW-8){1'b0}}};
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_state <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          if (!r_z[IW-1]) begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan_s;
          end else begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan_s;
          end
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(ITER - 1)) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_sin   <= w_sin;
          r_cos   <= w_cos;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign sin       = r_sin;
  assign cos       = r_cos;

`ifdef CORDIC_SINCOS_DUTY_EN
  logic [8:0] r_sin_duty;
  logic [8:0] r_cos_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sin_duty <= 9'd128;
      r_cos_duty <= 9'd128;
    end else if (r_state == S_FINISH) begin
      r_sin_duty <= {w_sin[7], w_sin} + 9'd128;
      r_cos_duty <= {w_cos[7], w_cos} + 9'd128;
    end
  end

  assign sin_duty = r_sin_duty;
  assign cos_duty = r_cos_duty;
`endif

endmodule
`default_nettype wire

// File: doc/cordic_sincos.md
# cordic_sincos

Iterative CORDIC sine/cosine generator that converts an 8-bit phase word into signed 8-bit sine and cosine samples. It sits directly upstream of the PWM duty registers in the LED-breathing path and replaces the table-based sine generator with a multiplier-free, area-lean rotation engine. A one-cycle request/response handshake lets the phase counter trigger a new sample whenever the previous one has been delivered.

## Interface
- `ITER`, 8: CORDIC iterations per sample; legal range 6–11.
- `IW`, 12: angle and fraction width in bits; `IW` ≥ 10. The x/y datapath is `IW`+2 bits.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: phase request.
- `in_ready` out 1: block idle and able to accept a phase.
- `phase` in 8: angle; 256 counts per full turn.
- `out_valid` out 1: one-cycle pulse when `sin`/`cos` update.
- `sin` out 8: signed sample in [-127, 127].
- `cos` out 8: signed sample in [-127, 127].

## Operation
- FSM has three states: IDLE, ROTATE, FINISH.
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid` & `in_ready`:
    - latch quadrant `q` = `phase[7:6]`
    - x ← `X0`, y ← 0, z ← `phase[5:0]` << (`IW`-8), iteration counter ← 0
    - go to ROTATE.
- **ROTATE**
  - Each cycle, let i = counter:
    - if z ≥ 0: x ← x − (y>>>i); y ← y + (x>>>i); z ← z − ATAN[i]
    - else: x ← x + (y>>>i); y ← y − (x>>>i); z ← z + ATAN[i].
  - All updates use pre-update values.
  - After `ITER` iterations, go to FINISH.
- **FINISH**
  - Quadrant map:
    - q=0: (sin, cos) = (y, x)
    - q=1: (x, −y)
    - q=2: (−y, −x)
    - q=3: (−x, y).
  - Each result: arithmetic shift right by `IW`−8 with round-half-up, then saturate to [-127, 127].
  - Register `sin`/`cos`, pulse `out_valid`, go to IDLE.
- `X0` = round(127·2^(`IW`−8) / K), where K = ∏√(1+2^−2i) over the `ITER` iterations. For `IW`=12, `ITER`=8: `X0` = 1234.
- ATAN[i] = round(atan(2^−i)·2^`IW`/(2π)).
- `in_valid` is ignored outside IDLE; requests are never queued.
- `sin`/`cos` hold their values between results.
- **Reset values:**
  - `sin` = 0, `cos` = 0, `out_valid` = 0
  - `in_ready` = 1, state IDLE
  - datapath registers 0
  - duty outputs 128 when enabled (see Configuration).
- Asserting `rst` mid-rotation aborts the sample. No `out_valid` is produced for the aborted request.

## Timing
- Acceptance edge T. ROTATE covers edges T+1..T+`ITER`; FINISH updates at edge T+`ITER`+1.
- `out_valid` and the new `sin`/`cos` are visible in the cycle after edge T+`ITER`+1. Latency is `ITER`+1 edges.
- `in_ready` is high in the same cycle as `out_valid`. With `in_valid` held high, throughput is one sample per `ITER`+2 cycles (10 for defaults).
- Phase wrap 255→0 needs no special case. Quadrant folding keeps z within [0, π/2).

## Configuration
- `CORDIC_SINCOS_DUTY_EN`
  - Defined: adds outputs `sin_duty` and `cos_duty`, each 9 bits.
  - Value is offset-binary: sample + 128, range 1..255.
  - Registered together with `sin`/`cos`; reset value 128.
  - Feeds the PWM duty input directly, with no external adder.
  - Undefined: these ports and registers do not exist.

## Structure
- Shared package `cordic_pkg` holds:
  - FSM state enum
  - `X0` and gain K computation functions
  - quadrant encoding constants.
- Sub-module `cordic_atan_rom`: combinational ATAN[i] lookup, parameterised by `IW`, indexed by the iteration counter.

## Test plan
- Phase 0 → `sin` = 0 ±1, `cos` = 127 ±1.
- Phase 64 → `sin` = 127 ±1, `cos` = 0 ±1.
- Phase 128 → `sin` = 0 ±1, `cos` = −127 ±1.
- Phase 32 → `sin` = `cos` = 90 ±1.
- Phase 224 → `sin` = −90 ±1, `cos` = 90 ±1.
- `in_valid` held high over phases 0..255:
  - `out_valid` pulses every 10 cycles
  - `in_ready` is high only in IDLE cycles
  - every result is within ±1 of round(127·sin).
- `rst` asserted at ROTATE iteration 4 → outputs immediately 0, `in_ready` = 1, no `out_valid` pulse follows.
- With `CORDIC_SINCOS_DUTY_EN` defined, phase 64 → `sin_duty` = 255 ±1, `cos_duty` = 128 ±1.
- With `CORDIC_SINCOS_DUTY_EN` defined, after reset `sin_duty` = `cos_duty` = 128.
